flash_cfg_reader: RTL and testbench



---
 rtl/flash_cfg_reader.sv | 127 ++++++++++++
 tb/tb_flash_cfg_reader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cfg_reader.sv
// rtl/flash_cfg_reader.sv - SPI-flash READ sequencer returning NBYTES bytes as a flat vector
module flash_cfg_reader #(
    parameter logic [7:0]  CMD       = 8'h03,
    parameter logic [23:0] ADDR      = 24'h00704D,
    parameter int          NBYTES    = 1,
    parameter int          CSW       = 4,
    parameter bit          AUTOSTART = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   q,
    output logic                  cs,
    output logic                  ck,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int QW = 8 * NBYTES;
    localparam int CW = $clog2(32 + 8 * 16 + 1);
    localparam logic [CW-1:0] NBITS   = CW'(32 + QW);
    localparam logic [CW-1:0] RX_BITS = CW'(QW);
    localparam logic [CW-1:0] CSW_C   = CW'(CSW);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, FIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          phase;
    logic          pending;
    logic          arm;
    logic [31:0]   tx;
    logic [QW-1:0] shadow;
    logic [QW-1:0] swapped;

    // First byte on the wire ends up in the top of shadow; present it in q[7:0].
    always_comb begin
        swapped = '0;
        for (int i = 0; i < NBYTES; i++) begin
            swapped[8*i +: 8] = shadow[8*(NBYTES-1-i) +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= 1'b0;
            pending <= 1'b0;
            arm     <= AUTOSTART;
            tx      <= '0;
            shadow  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= {NBYTES{8'hFF}};
            cs      <= 1'b1;
            ck      <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            arm <= 1'b0;
            if ((arm || start) && state == IDLE && !pending) begin
                pending <= 1'b1;
                busy    <= 1'b1;
                done    <= 1'b0;
            end
            if (ce) begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            pending <= 1'b0;
                            cs      <= 1'b0;
                            cnt     <= CSW_C;
                            state   <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (cnt == CW'(1)) begin
                            tx    <= {CMD, ADDR};
                            cnt   <= NBITS;
                            phase <= 1'b0;
                            state <= SHIFT;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    SHIFT: begin
                        if (cnt == '0) begin
                            ck    <= 1'b0;
                            cnt   <= CSW_C;
                            state <= HOLD;
                        end else if (!phase) begin
                            // tx zero-fills, so mosi idles low once the header is out
                            ck    <= 1'b0;
                            mosi  <= tx[31];
                            tx    <= {tx[30:0], 1'b0};
                            phase <= 1'b1;
                        end else begin
                            ck <= 1'b1;
                            if (cnt <= RX_BITS) begin
                                shadow <= {shadow[QW-2:0], miso};
                            end
                            cnt   <= cnt - CW'(1);
                            phase <= 1'b0;
                        end
                    end
                    HOLD: begin
                        cs <= 1'b1;
                        if (cnt == CW'(1)) begin
                            state <= FIN;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    FIN: begin
                        q     <= swapped;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_flash_cfg_reader.sv
// tb/tb_flash_cfg_reader.sv - randomized bench for flash_cfg_reader with a behavioural SPI flash
module tb_flash_cfg_reader;
    localparam int NB_A = 1;
    localparam int NB_B = 4;
    localparam int CSW_A = 4;
    localparam int CSW_B = 3;
    localparam logic [23:0] AD_A = 24'h00704D;
    localparam logic [23:0] AD_B = 24'h1A2B3C;
    localparam logic [7:0]  RD_CMD = 8'h03;

    logic       clock;
    logic       ce;
    logic [1:0] rst_n_v;
    logic [1:0] start_v;
    bit         ce_hold;
    int         ce_pct;
    int         ce_ticks = 0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] mem [int];

    logic        busy_o  [2];
    logic        done_o  [2];
    logic        cs_o    [2];
    logic        ck_o    [2];
    logic        mosi_o  [2];
    logic [31:0] q_o     [2];
    int          rises_o [2];
    logic [31:0] hdr_o   [2];
    bit          early_o [2];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int NB  = (g == 0) ? NB_A : NB_B;
        localparam int CWD = (g == 0) ? CSW_A : CSW_B;
        localparam logic [23:0] AD = (g == 0) ? AD_A : AD_B;
        localparam bit AS = (g == 0) ? 1'b0 : 1'b1;
        logic busy, done, cs, ck, mosi;
        logic [8*NB-1:0] q;
        logic miso_m = 1'b0;
        logic cs_q = 1'b1;
        logic ck_q = 1'b0;
        int nbits = 0;
        int rises = 0;
        logic [31:0] hdr = '0;
        bit early = 1'b0;

        flash_cfg_reader #(.CMD(RD_CMD), .ADDR(AD), .NBYTES(NB), .CSW(CWD), .AUTOSTART(AS)) u_dut (
            .clock(clock), .reset(rst_n_v[g]), .ce(ce), .start(start_v[g]),
            .busy(busy), .done(done), .q(q), .cs(cs), .ck(ck), .mosi(mosi), .miso(miso_m)
        );

        // SPI flash: latch cmd+addr on ck rise, drive data MSB first after each ck fall
        always @(cs or ck) begin
            int a;
            logic [7:0] b;
            if (cs_q === 1'b1 && cs === 1'b0) begin
                nbits = 0; rises = 0; early = 1'b0;
            end
            if (cs_q === 1'b0 && cs === 1'b1 && rises < 32 + 8*NB) early = 1'b1;
            if (cs === 1'b0 && ck_q === 1'b0 && ck === 1'b1) begin
                rises++;
                if (nbits < 32) hdr = {hdr[30:0], mosi};
                nbits++;
            end
            if (cs === 1'b0 && ck_q === 1'b1 && ck === 1'b0 && nbits >= 32 && nbits - 32 < 8*NB) begin
                a = int'(hdr[23:0]) + (nbits - 32) / 8;
                b = mem.exists(a) ? mem[a] : 8'hFF;
                miso_m = b[7 - (nbits - 32) % 8];
            end
            cs_q = cs;
            ck_q = ck;
        end

        assign busy_o[g] = busy;
        assign done_o[g] = done;
        assign cs_o[g] = cs;
        assign ck_o[g] = ck;
        assign mosi_o[g] = mosi;
        assign q_o[g] = 32'(q);
        assign rises_o[g] = rises;
        assign hdr_o[g] = hdr;
        assign early_o[g] = early;
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        ce = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            ce = ce_hold ? 1'b0 : ($urandom_range(1, 100) <= ce_pct);
        end
    end

    always @(posedge clock) if (ce) ce_ticks++;

    function automatic int nb_of(input int g);
        return (g == 0) ? NB_A : NB_B;
    endfunction

    function automatic int addr_of(input int g);
        return (g == 0) ? int'(AD_A) : int'(AD_B);
    endfunction

    function automatic int lat_of(input int g);
        int c;
        c = (g == 0) ? CSW_A : CSW_B;
        return 2*c + 2*(32 + 8*nb_of(g)) + 2;
    endfunction

    function automatic logic [31:0] exp_q(input int g);
        logic [31:0] r;
        int a;
        r = '0;
        for (int i = 0; i < nb_of(g); i++) begin
            a = addr_of(g) + i;
            r[8*i +: 8] = mem.exists(a) ? mem[a] : 8'hFF;
        end
        return r;
    endfunction

    task automatic fill_random(input int g);
        for (int i = 0; i < nb_of(g); i++) mem[addr_of(g) + i] = 8'($urandom);
    endtask

    // Runs one transaction and reports observations; tests do the comparing.
    task automatic do_txn(input int g, input bit pulse, input bit poke, input bit freeze,
                          output int lat, output logic [31:0] qv, output bit acc_ok,
                          output bit partial, output bit frz_ok, output bit timeout);
        int t0;
        logic [31:0] q0;
        logic [68:0] snap;
        bit poked;
        bit frozen;
        acc_ok = 1'b0; partial = 1'b0; frz_ok = 1'b1; timeout = 1'b1;
        poked = 1'b0; frozen = 1'b0;
        @(negedge clock);
        if (pulse) start_v[g] = 1'b1;
        else rst_n_v[g] = 1'b1;
        @(negedge clock);
        start_v[g] = 1'b0;
        t0 = ce_ticks;
        acc_ok = (busy_o[g] === 1'b1) && (done_o[g] === 1'b0);
        q0 = q_o[g];
        for (int i = 0; i < 20000; i++) begin
            @(negedge clock);
            start_v[g] = 1'b0;
            if (done_o[g] === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (q_o[g] !== q0) partial = 1'b1;
            if (poke && !poked && rises_o[g] >= 36) begin
                start_v[g] = 1'b1;
                poked = 1'b1;
            end
            if (freeze && !frozen && rises_o[g] >= 20) begin
                frozen = 1'b1;
                ce_hold = 1'b1;
                snap = {cs_o[g], ck_o[g], mosi_o[g], busy_o[g], done_o[g], q_o[g], rises_o[g]};
                repeat (8) begin
                    @(negedge clock);
                    if ({cs_o[g], ck_o[g], mosi_o[g], busy_o[g], done_o[g], q_o[g], rises_o[g]} !== snap)
                        frz_ok = 1'b0;
                end
                ce_hold = 1'b0;
            end
        end
        lat = ce_ticks - t0 - 1;
        qv = q_o[g];
    endtask

    task automatic test_reset;
        rst_n_v = 2'b00;
        repeat (3) @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({cs_o[g], ck_o[g], mosi_o[g], busy_o[g], done_o[g]} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: cs,ck,mosi,busy,done=%b want 10000", g,
                         {cs_o[g], ck_o[g], mosi_o[g], busy_o[g], done_o[g]});
            end
            checks++;
            if (q_o[g] !== ((g == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF)) begin
                errors++;
                $display("FAIL reset_q[%0d]: got %h want erased", g, q_o[g]);
            end
        end
        rst_n_v[0] = 1'b1;
        repeat (20) @(negedge clock);
        checks++;
        if (busy_o[0] !== 1'b0 || cs_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL no_autostart: busy=%b cs=%b want 0 1", busy_o[0], cs_o[0]);
        end
    endtask

    task automatic test_single_byte;
        int lat; logic [31:0] qv; bit acc, part, frz, to;
        mem[int'(AD_A)] = 8'h02;
        do_txn(0, 1'b1, 1'b0, 1'b0, lat, qv, acc, part, frz, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout: done never rose"); end
        checks++;
        if (!acc) begin errors++; $display("FAIL single_accept: busy=0 or done=1 after start"); end
        checks++;
        if (lat !== 90) begin errors++; $display("FAIL single_latency: got %0d want 90", lat); end
        checks++;
        if (qv !== 32'h02) begin errors++; $display("FAIL single_q: got %h want 02", qv); end
        checks++;
        if (hdr_o[0] !== 32'h0300704D) begin
            errors++; $display("FAIL single_mosi: got %h want 0300704D", hdr_o[0]);
        end
        checks++;
        if (rises_o[0] !== 40) begin errors++; $display("FAIL single_ck: got %0d want 40", rises_o[0]); end
        checks++;
        if (part) begin errors++; $display("FAIL single_partial: q changed before done"); end
        checks++;
        if ({busy_o[0], cs_o[0], ck_o[0]} !== 3'b010) begin
            errors++; $display("FAIL single_idle: busy,cs,ck=%b want 010", {busy_o[0], cs_o[0], ck_o[0]});
        end
    endtask

    task automatic test_start_while_busy;
        int lat; logic [31:0] qv; bit acc, part, frz, to, idle_ok;
        fill_random(0);
        do_txn(0, 1'b1, 1'b1, 1'b0, lat, qv, acc, part, frz, to);
        checks++;
        if (to) begin errors++; $display("FAIL busy_timeout: done never rose"); end
        checks++;
        if (rises_o[0] !== 40) begin errors++; $display("FAIL busy_ck: got %0d want 40", rises_o[0]); end
        checks++;
        if (qv !== exp_q(0)) begin errors++; $display("FAIL busy_q: got %h want %h", qv, exp_q(0)); end
        idle_ok = 1'b1;
        repeat (300) begin
            @(negedge clock);
            if (busy_o[0] !== 1'b0 || cs_o[0] !== 1'b1 || done_o[0] !== 1'b1) idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok) begin errors++; $display("FAIL busy_queued: a second transaction started"); end
    endtask

    task automatic test_ce_freeze;
        int lat; logic [31:0] qv; bit acc, part, frz, to;
        fill_random(0);
        do_txn(0, 1'b1, 1'b0, 1'b1, lat, qv, acc, part, frz, to);
        checks++;
        if (!frz) begin errors++; $display("FAIL ce_freeze: outputs moved while ce low"); end
        checks++;
        if (qv !== exp_q(0) || lat !== lat_of(0)) begin
            errors++; $display("FAIL freeze_txn: q=%h lat=%0d want %h %0d", qv, lat, exp_q(0), lat_of(0));
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] qv; bit acc, part, frz, to, reached;
        fill_random(0);
        @(negedge clock);
        start_v[0] = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            if (rises_o[0] >= 12) begin reached = 1'b1; break; end
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL rstmid_reach: address phase never reached"); end
        rst_n_v[0] = 1'b0;
        @(negedge clock);
        checks++;
        if ({cs_o[0], ck_o[0], busy_o[0], done_o[0]} !== 4'b1000 || q_o[0] !== 32'hFF) begin
            errors++;
            $display("FAIL rstmid_edge: cs,ck,busy,done=%b q=%h want 1000 ff",
                     {cs_o[0], ck_o[0], busy_o[0], done_o[0]}, q_o[0]);
        end
        @(negedge clock);
        mem[int'(AD_A)] = 8'hA5;
        do_txn(0, 1'b0, 1'b0, 1'b0, lat, qv, acc, part, frz, to);
        @(negedge clock);
        start_v[0] = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        checks++;
        if (acc) begin errors++; $display("FAIL rstmid_release: reset release alone started a read"); end
        do_txn(0, 1'b1, 1'b0, 1'b0, lat, qv, acc, part, frz, to);
        checks++;
        if (part) begin errors++; $display("FAIL rstmid_partial: q left ff before done"); end
        checks++;
        if (qv !== 32'hA5 || to) begin errors++; $display("FAIL rstmid_q: got %h want a5", qv); end
    endtask

    task automatic test_autostart;
        int lat; logic [31:0] qv; bit acc, part, frz, to;
        fill_random(1);
        do_txn(1, 1'b0, 1'b0, 1'b0, lat, qv, acc, part, frz, to);
        checks++;
        if (to || !acc) begin errors++; $display("FAIL auto_start: to=%b accepted=%b want 0 1", to, acc); end
        checks++;
        if (lat !== lat_of(1)) begin errors++; $display("FAIL auto_latency: got %0d want %0d", lat, lat_of(1)); end
        checks++;
        if (qv !== exp_q(1)) begin errors++; $display("FAIL auto_q: got %h want %h", qv, exp_q(1)); end
        checks++;
        if (hdr_o[1] !== {RD_CMD, AD_B}) begin
            errors++; $display("FAIL auto_mosi: got %h want %h", hdr_o[1], {RD_CMD, AD_B});
        end
    endtask

    task automatic test_multi_byte;
        int lat; logic [31:0] qv; bit acc, part, frz, to;
        mem[int'(AD_B)] = 8'h11; mem[int'(AD_B) + 1] = 8'h22;
        mem[int'(AD_B) + 2] = 8'h33; mem[int'(AD_B) + 3] = 8'h44;
        do_txn(1, 1'b1, 1'b0, 1'b0, lat, qv, acc, part, frz, to);
        checks++;
        if (qv !== 32'h44332211 || to) begin errors++; $display("FAIL multi_q: got %h want 44332211", qv); end
        checks++;
        if (early_o[1] || rises_o[1] !== 64) begin
            errors++; $display("FAIL multi_cs: early=%b ck=%0d want 0 64", early_o[1], rises_o[1]);
        end
    endtask

    task automatic test_random;
        int lat; logic [31:0] qv; bit acc, part, frz, to;
        int g;
        for (int n = 0; n < 8; n++) begin
            g = n % 2;
            ce_pct = (n % 3 == 0) ? 100 : $urandom_range(20, 90);
            fill_random(g);
            do_txn(g, 1'b1, 1'b0, 1'b0, lat, qv, acc, part, frz, to);
            checks++;
            if (to || !acc || part || qv !== exp_q(g) || lat !== lat_of(g)) begin
                errors++;
                $display("FAIL random[%0d]: q=%h lat=%0d acc=%b to=%b want q=%h lat=%0d",
                         n, qv, lat, acc, to, exp_q(g), lat_of(g));
            end
        end
        ce_pct = 60;
    endtask

    initial begin
        rst_n_v = 2'b00;
        start_v = 2'b00;
        ce_hold = 1'b0;
        ce_pct = 60;
        test_reset;
        test_single_byte;
        test_start_while_busy;
        test_ce_freeze;
        test_reset_mid;
        test_autostart;
        test_multi_byte;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
